dds_sincos_gen: RTL and testbench



---
 rtl/dds_sincos_gen.sv | 122 ++++++++++++
 tb/tb_dds_sincos_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sincos_gen.sv
// dds_sincos_gen: quadrature sine/cosine synthesizer.
// A 64-step phase wheel advances once every max(period,1) clocks; a 17-entry
// quarter-wave ROM plus quadrant symmetry produces 8-bit signed sin/cos samples.
// Outputs are registered from the pre-update phase (one cycle phase->output).
// Optional build macro: DDS_PERIOD_CHANGE_RESTART_EN -- when defined, any change
// of `period` after the first post-reset edge restarts the wheel at phase 0.
module dds_sincos_gen (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        period,
  output logic signed [7:0] my_sine_out,
  output logic signed [7:0] my_cosine_out
);

  logic [7:0] prescaler;
  logic [5:0] phase;
  logic [7:0] eff_period;
  logic       step;
  logic       restart;

  // Quarter-wave magnitude table, round(127*sin(2*pi*k/64)) for k = 0..16.
  function automatic logic [6:0] lut(input logic [4:0] k);
    logic [6:0] v;
    case (k)
      5'd0:    v = 7'd0;
      5'd1:    v = 7'd12;
      5'd2:    v = 7'd25;
      5'd3:    v = 7'd37;
      5'd4:    v = 7'd49;
      5'd5:    v = 7'd60;
      5'd6:    v = 7'd71;
      5'd7:    v = 7'd81;
      5'd8:    v = 7'd90;
      5'd9:    v = 7'd98;
      5'd10:   v = 7'd106;
      5'd11:   v = 7'd112;
      5'd12:   v = 7'd117;
      5'd13:   v = 7'd122;
      5'd14:   v = 7'd125;
      5'd15:   v = 7'd126;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  // Full-wave sine from the quarter table: odd quadrants mirror the index,
  // upper half-wave negates. Magnitudes top out at 127, so no saturation.
  function automatic logic signed [7:0] sin_of(input logic [5:0] p);
    logic [1:0]        q;
    logic [3:0]        i;
    logic [6:0]        mag;
    logic signed [7:0] m8;
    q   = p[5:4];
    i   = p[3:0];
    mag = q[0] ? lut(5'd16 - {1'b0, i}) : lut({1'b0, i});
    m8  = signed'({1'b0, mag});
    return q[1] ? -m8 : m8;
  endfunction

  // A period of 0 behaves as 1; >= compare lets a shrinking period wrap at once.
  always_comb begin
    eff_period = (period == 8'd0) ? 8'd1 : period;
    step       = (prescaler >= (eff_period - 8'd1));
  end

`ifdef DDS_PERIOD_CHANGE_RESTART_EN
  logic [7:0] period_q;
  logic       primed;

  // Remember the last period seen; primed blocks a restart on the first edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= 8'd0;
      primed   <= 1'b0;
    end else begin
      period_q <= period;
      primed   <= 1'b1;
    end
  end

  // A period change after priming restarts the waveform phase-aligned.
  always_comb begin
    restart = primed && (period != period_q);
  end
`else
  // Phase stays continuous across period changes in this build.
  always_comb begin
    restart = 1'b0;
  end
`endif

  // Prescaler and phase wheel; phase wraps naturally at 6 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= 8'd0;
      phase     <= 6'd0;
    end else if (restart) begin
      prescaler <= 8'd0;
      phase     <= 6'd0;
    end else if (step) begin
      prescaler <= 8'd0;
      phase     <= phase + 6'd1;
    end else begin
      prescaler <= prescaler + 8'd1;
    end
  end

  // Output samples from the current (pre-update) phase; restart forces phase 0 values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      my_sine_out   <= 8'sd0;
      my_cosine_out <= 8'sd127;
    end else if (restart) begin
      my_sine_out   <= 8'sd0;
      my_cosine_out <= 8'sd127;
    end else begin
      my_sine_out   <= sin_of(phase);
      my_cosine_out <= sin_of(phase + 6'd16);
    end
  end

endmodule

// File: tb/tb_dds_sincos_gen.sv
// tb_dds_sincos_gen: randomized bench for dds_sincos_gen against a model that
// derives samples from real-valued sin/cos and tracks the phase wheel by count.
module tb_dds_sincos_gen;

  logic              clk;
  logic              reset;
  logic [7:0]        period;
  logic signed [7:0] my_sine_out;
  logic signed [7:0] my_cosine_out;

  int vectors    = 0;
  int miscompares = 0;

  // model state
  int                m_hold;     // clocks spent on the current phase step
  int                m_phase;    // 0..63
  logic signed [7:0] m_s;
  logic signed [7:0] m_c;
  logic [7:0]        m_pq;
  bit                m_primed;

  int lut_tab[17] = '{0, 12, 25, 37, 49, 60, 71, 81, 90, 98, 106, 112, 117, 122, 125, 126, 127};

  dds_sincos_gen dut (
    .clk           (clk),
    .reset         (reset),
    .period        (period),
    .my_sine_out   (my_sine_out),
    .my_cosine_out (my_cosine_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // round-half-away-from-zero of 127*f
  function automatic logic signed [7:0] scale127(input real f);
    real v;
    int  r;
    v = 127.0 * f;
    if (v >= 0.0) r = int'($floor(v + 0.5));
    else          r = -int'($floor(-v + 0.5));
    return 8'(r);
  endfunction

  function automatic logic signed [7:0] ref_sin(input int p);
    return scale127($sin(2.0 * 3.14159265358979 * real'(p) / 64.0));
  endfunction

  function automatic logic signed [7:0] ref_cos(input int p);
    return scale127($cos(2.0 * 3.14159265358979 * real'(p) / 64.0));
  endfunction

  // true when |v| is one of the published table values
  function automatic bit in_table(input logic signed [7:0] v);
    int a;
    a = (v < 0) ? -int'(v) : int'(v);
    foreach (lut_tab[k]) if (lut_tab[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_hold   = 0;
    m_phase  = 0;
    m_s      = 8'sd0;
    m_c      = 8'sd127;
    m_pq     = 8'd0;
    m_primed = 1'b0;
  endtask

  // one rising edge: advance model with the period applied to that edge
  task automatic tick();
    int  p_eff;
    bit  rst_now;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      p_eff   = (period == 8'd0) ? 1 : int'(period);
      rst_now = 1'b0;
`ifdef DDS_PERIOD_CHANGE_RESTART_EN
      rst_now = m_primed && (period != m_pq);
`endif
      if (rst_now) begin
        m_s     = 8'sd0;
        m_c     = 8'sd127;
        m_hold  = 0;
        m_phase = 0;
      end else begin
        m_s = ref_sin(m_phase);
        m_c = ref_cos(m_phase);
        if (m_hold + 1 >= p_eff) begin
          m_hold  = 0;
          m_phase = (m_phase + 1) % 64;
        end else begin
          m_hold = m_hold + 1;
        end
      end
      m_pq     = period;
      m_primed = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] p);
    @(negedge clk);
    period = p;
    #1 reset = 1'b1;
    model_reset();
    tick();
    tick();
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    period = 8'd16;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (my_sine_out !== 8'sd0 || my_cosine_out !== 8'sd127) begin
      miscompares++;
      $display("FAIL reset_async sin=%0d cos=%0d expected 0/127", my_sine_out, my_cosine_out);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (my_sine_out !== 8'sd0 || my_cosine_out !== 8'sd127) begin
        miscompares++;
        $display("FAIL reset_held sin=%0d cos=%0d expected 0/127", my_sine_out, my_cosine_out);
      end
    end
    #1 reset = 1'b0;
    // 16 edges still show phase 0; the 17th shows phase 1
    for (int i = 0; i < 17; i++) begin
      tick();
      vectors++;
      if (my_sine_out !== m_s || my_cosine_out !== m_c) begin
        miscompares++;
        $display("FAIL reset_release edge=%0d sin=%0d cos=%0d expected %0d/%0d",
                 i + 1, my_sine_out, my_cosine_out, m_s, m_c);
      end
    end
    vectors++;
    if (my_sine_out !== 8'sd12 || my_cosine_out !== 8'sd126) begin
      miscompares++;
      $display("FAIL first_step sin=%0d cos=%0d expected 12/126", my_sine_out, my_cosine_out);
    end
  endtask

  task automatic test_period16();
    logic signed [7:0] mn, mx;
    logic signed [7:0] hist[$];
    mn = 8'sd127;
    mx = -8'sd127;
    do_reset(8'd16);
    for (int i = 0; i < 1100; i++) begin
      tick();
      hist.push_back(my_sine_out);
      if (my_sine_out < mn) mn = my_sine_out;
      if (my_sine_out > mx) mx = my_sine_out;
      vectors++;
      if (my_sine_out !== m_s || my_cosine_out !== m_c || !in_table(my_sine_out)) begin
        miscompares++;
        $display("FAIL p16 cyc=%0d sin=%0d cos=%0d expected %0d/%0d",
                 i, my_sine_out, my_cosine_out, m_s, m_c);
      end
    end
    vectors++;
    if (mn !== -8'sd127 || mx !== 8'sd127) begin
      miscompares++;
      $display("FAIL p16_extremes min=%0d max=%0d expected -127/127", mn, mx);
    end
    vectors++;
    if (hist[10] !== hist[10 + 1024] || hist[60] !== hist[60 + 1024]) begin
      miscompares++;
      $display("FAIL p16_repeat got %0d,%0d expected %0d,%0d",
               hist[10 + 1024], hist[60 + 1024], hist[10], hist[60]);
    end
  endtask

  task automatic test_period1_0();
    logic signed [7:0] s1[$];
    do_reset(8'd1);
    for (int i = 0; i < 140; i++) begin
      tick();
      s1.push_back(my_sine_out);
      vectors++;
      if (my_sine_out !== m_s || my_cosine_out !== m_c) begin
        miscompares++;
        $display("FAIL p1 cyc=%0d sin=%0d cos=%0d expected %0d/%0d",
                 i, my_sine_out, my_cosine_out, m_s, m_c);
      end
    end
    do_reset(8'd0);
    for (int i = 0; i < 140; i++) begin
      tick();
      vectors++;
      if (my_sine_out !== s1[i] || my_sine_out !== m_s || my_cosine_out !== m_c) begin
        miscompares++;
        $display("FAIL p0 cyc=%0d sin=%0d cos=%0d expected %0d/%0d",
                 i, my_sine_out, my_cosine_out, m_s, m_c);
      end
    end
  endtask

  task automatic test_period_change();
    int guard;
    do_reset(8'd16);
    guard = 0;
    // run into phase 3 and stop when the hold count reads 10
    while (!(m_phase == 3 && m_hold == 10) && guard < 200) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL pchg_setup guard=%0d expected <200", guard);
    end
    period = 8'd4;
    for (int i = 0; i < 120; i++) begin
      tick();
      vectors++;
      if (my_sine_out !== m_s || my_cosine_out !== m_c ||
          !in_table(my_sine_out) || !in_table(my_cosine_out)) begin
        miscompares++;
        $display("FAIL pchg cyc=%0d sin=%0d cos=%0d expected %0d/%0d",
                 i, my_sine_out, my_cosine_out, m_s, m_c);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset(8'd2);
    guard = 0;
    while (m_phase != 40 && guard < 200) begin
      tick();
      guard++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (my_sine_out !== 8'sd0 || my_cosine_out !== 8'sd127) begin
      miscompares++;
      $display("FAIL async_pulse sin=%0d cos=%0d expected 0/127", my_sine_out, my_cosine_out);
    end
    model_reset();
    tick();
    #1 reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      vectors++;
      if (my_sine_out !== m_s || my_cosine_out !== m_c) begin
        miscompares++;
        $display("FAIL async_restart cyc=%0d sin=%0d cos=%0d expected %0d/%0d",
                 i, my_sine_out, my_cosine_out, m_s, m_c);
      end
    end
  endtask

  task automatic test_random_periods();
    int seg;
    do_reset(8'($urandom_range(0, 12)));
    for (int s = 0; s < 30; s++) begin
      period = 8'($urandom_range(0, 12));
      seg = $urandom_range(1, 90);
      for (int i = 0; i < seg; i++) begin
        tick();
        vectors++;
        if (my_sine_out !== m_s || my_cosine_out !== m_c) begin
          miscompares++;
          $display("FAIL random seg=%0d p=%0d sin=%0d cos=%0d expected %0d/%0d",
                   s, period, my_sine_out, my_cosine_out, m_s, m_c);
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    period = 8'd16;
    model_reset();
    test_reset();
    test_period16();
    test_period1_0();
    test_period_change();
    test_async_reset();
    test_random_periods();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
